// File: rtl/inst_mem_resp_pkg.sv
// Shared constants and types for the instruction-memory responder.
// Holds the fetch address/data widths, the error-bit layout and the fetch error classifier.
package inst_mem_resp_pkg;

   localparam int INST_ADDR_WIDTH = 32;
   localparam int REG_DATA_WIDTH  = 32;
   localparam int INST_DATA_WIDTH = 32;
   localparam int ERR_WIDTH       = 2;
   localparam int WAIT_CNT_WIDTH  = 4;

   localparam logic [INST_DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013;

   localparam int ERR_MISALIGN = 0;
   localparam int ERR_OOB      = 1;

   typedef struct packed {
      logic [INST_DATA_WIDTH-1:0] inst;
      logic [ERR_WIDTH-1:0]       err;
   } resp_t;

   // Range check uses the full byte address, so addresses past the array never alias back in.
   function automatic logic [ERR_WIDTH-1:0] fetch_err(
      input logic [INST_ADDR_WIDTH-1:0] addr,
      input logic [INST_ADDR_WIDTH-1:0] depth_words
   );
      logic [ERR_WIDTH-1:0] err;
      err               = {ERR_WIDTH{1'b0}};
      err[ERR_MISALIGN] = (addr[1:0] != 2'b00);
      err[ERR_OOB]      = ((addr >> 2) >= depth_words);
      return err;
   endfunction

endpackage

// File: rtl/inst_mem_resp_if.sv
// Fetch request/response channel between the IF stage (master) and instruction memory (slave).
interface inst_mem_resp_if;
   import inst_mem_resp_pkg::*;

   logic                       req_valid;
   logic                       req_ready;
   logic [INST_ADDR_WIDTH-1:0] req_addr;
   logic                       resp_valid;
   logic                       resp_ready;
   logic [INST_DATA_WIDTH-1:0] resp_inst;
   logic [ERR_WIDTH-1:0]       resp_err;

   modport master (
      output req_valid,
      output req_addr,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_inst,
      input  resp_err
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_inst,
      output resp_err
   );

endinterface

// File: rtl/inst_mem_resp_ram.sv
// Program image storage: synchronous write port, combinational read port.
// A read of the word being written on the same edge sees the old contents.
module inst_ram
   import inst_mem_resp_pkg::*;
#(
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [AW-1:0]              wr_addr,
   input  logic [INST_DATA_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]              rd_addr,
   output logic [INST_DATA_WIDTH-1:0] rd_data
);

   logic [INST_DATA_WIDTH-1:0] mem_q [DEPTH];

   // Load-port write; the array has no reset so the image survives a core reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: accepts one fetch at a time, waits WAIT_CYCLES states,
// then presents the instruction word (or NOP on error) until the fetch side takes it.
module inst_mem_resp
   import inst_mem_resp_pkg::*;
#(
   parameter int                         DEPTH       = 256,
   parameter int                         WAIT_CYCLES = 1,
   parameter logic [INST_DATA_WIDTH-1:0] NOP_INST    = inst_mem_resp_pkg::NOP_INST,
   localparam int                        AW          = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       reset,
   inst_mem_resp_if.slave             bus,
   input  logic                       ld_en,
   input  logic [AW-1:0]              ld_addr,
   input  logic [INST_DATA_WIDTH-1:0] ld_data
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [WAIT_CNT_WIDTH-1:0]  WAIT_INIT   = WAIT_CNT_WIDTH'(WAIT_CYCLES);
   localparam logic [INST_ADDR_WIDTH-1:0] DEPTH_WORDS = INST_ADDR_WIDTH'(DEPTH);

   state_e                      state_q, state_d;
   logic [WAIT_CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [INST_ADDR_WIDTH-1:0]  addr_q, addr_d;
   resp_t                       resp_q, resp_d;
   logic                        req_ready_q, req_ready_d;
   logic                        resp_valid_q, resp_valid_d;

   logic                        capture_s;
   logic [INST_ADDR_WIDTH-1:0]  cap_addr_s;
   logic [ERR_WIDTH-1:0]        cap_err_s;
   logic [INST_DATA_WIDTH-1:0]  rd_data_s;

   inst_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ld_en),
      .wr_addr (ld_addr),
      .wr_data (ld_data),
      .rd_addr (cap_addr_s[AW+1:2]),
      .rd_data (rd_data_s)
   );

   // With zero wait states the capture happens on the accept edge, before addr_q is loaded.
   assign cap_addr_s = (state_q == ST_IDLE) ? bus.req_addr : addr_q;
   assign cap_err_s  = fetch_err(cap_addr_s, DEPTH_WORDS);

   // Next-state, wait counter and capture strobe.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      capture_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               addr_d = bus.req_addr;
               if (WAIT_CYCLES == 0) begin
                  state_d   = ST_RESP;
                  cnt_d     = {WAIT_CNT_WIDTH{1'b0}};
                  capture_s = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d   = ST_RESP;
               cnt_d     = {WAIT_CNT_WIDTH{1'b0}};
               capture_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {WAIT_CNT_WIDTH{1'b0}};
         end
      endcase
   end

   // Output register inputs: response word frozen between capture and handshake.
   always_comb begin
      resp_d = resp_q;
      if (capture_s) begin
         resp_d.err  = cap_err_s;
         resp_d.inst = (cap_err_s != {ERR_WIDTH{1'b0}}) ? NOP_INST : rd_data_s;
      end else begin
         resp_d = resp_q;
      end
      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
   end

   // State and output registers with synchronous reset; reset drops any in-flight fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= {WAIT_CNT_WIDTH{1'b0}};
         addr_q       <= {INST_ADDR_WIDTH{1'b0}};
         resp_q       <= '{inst: {INST_DATA_WIDTH{1'b0}}, err: {ERR_WIDTH{1'b0}}};
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         resp_q       <= resp_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_inst  = resp_q.inst;
   assign bus.resp_err   = resp_q.err;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: three instances (0, 1 and 3 wait states) sharing the load port,
// checked against an array model of the program image and arithmetic error rules.
module tb_inst_mem_resp;

   localparam int DEPTH = 256;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        resp_ready;
   logic [31:0] req_addr;
   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [31:0] ld_data;
   int          sel;

   logic        cur_rv, cur_rr;
   logic [31:0] cur_ri;
   logic [1:0]  cur_re;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [31:0] model_mem [DEPTH];
   int          wait_of [3] = '{0, 1, 3};

   always #5 clk = ~clk;

   inst_mem_resp_if bus0 ();
   inst_mem_resp_if bus1 ();
   inst_mem_resp_if bus2 ();

   assign bus0.req_valid  = req_valid & (sel == 0);
   assign bus1.req_valid  = req_valid & (sel == 1);
   assign bus2.req_valid  = req_valid & (sel == 2);
   assign bus0.resp_ready = resp_ready & (sel == 0);
   assign bus1.resp_ready = resp_ready & (sel == 1);
   assign bus2.resp_ready = resp_ready & (sel == 2);
   assign bus0.req_addr   = req_addr;
   assign bus1.req_addr   = req_addr;
   assign bus2.req_addr   = req_addr;

   inst_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
   inst_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
   inst_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2.slave),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

   always_comb begin
      cur_rv = bus1.resp_valid;
      cur_rr = bus1.req_ready;
      cur_ri = bus1.resp_inst;
      cur_re = bus1.resp_err;
      case (sel)
         0: begin
            cur_rv = bus0.resp_valid; cur_rr = bus0.req_ready;
            cur_ri = bus0.resp_inst;  cur_re = bus0.resp_err;
         end
         2: begin
            cur_rv = bus2.resp_valid; cur_rr = bus2.req_ready;
            cur_ri = bus2.resp_inst;  cur_re = bus2.resp_err;
         end
         default: ;
      endcase
   end

   function automatic logic [1:0] exp_err(input logic [31:0] a);
      logic [1:0] e;
      e[0] = (a % 32'd4) != 32'd0;
      e[1] = (a / 32'd4) >= 32'(DEPTH);
      return e;
   endfunction

   function automatic logic [31:0] exp_inst(input logic [31:0] a);
      if (exp_err(a) != 2'b00) return NOP;
      return model_mem[a / 32'd4];
   endfunction

   task automatic load_word(input int idx, input logic [31:0] data);
      ld_en = 1'b1; ld_addr = 8'(idx); ld_data = data;
      @(posedge clk); #1;
      ld_en = 1'b0;
      model_mem[idx] = data;
   endtask

   // Presents req at posedge+1; lat counts edges from presentation until resp_valid is seen.
   task automatic run_fetch(input int s, input logic [31:0] a, input int stall,
                            output logic [31:0] inst, output logic [1:0] err, output int lat,
                            output bit held, output logic post_rv, output logic post_rr);
      sel = s; req_addr = a; resp_ready = (stall == 0); req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (cur_rv !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      inst = cur_ri; err = cur_re; held = 1'b1;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         if (cur_ri !== inst || cur_re !== err || cur_rr !== 1'b0 || cur_rv !== 1'b1) held = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      post_rv = cur_rv; post_rr = cur_rr;
   endtask

   task automatic test_reset();
      logic rr [3], rv [3];
      logic [31:0] ri [3];
      logic [1:0] re [3];
      rr[0] = bus0.req_ready; rv[0] = bus0.resp_valid; ri[0] = bus0.resp_inst; re[0] = bus0.resp_err;
      rr[1] = bus1.req_ready; rv[1] = bus1.resp_valid; ri[1] = bus1.resp_inst; re[1] = bus1.resp_err;
      rr[2] = bus2.req_ready; rv[2] = bus2.resp_valid; ri[2] = bus2.resp_inst; re[2] = bus2.resp_err;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (rr[i] !== 1'b1 || rv[i] !== 1'b0 || ri[i] !== 32'h0 || re[i] !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_state[%0d]: got rr=%b rv=%b inst=%h err=%b, want rr=1 rv=0 inst=0 err=00",
                     i, rr[i], rv[i], ri[i], re[i]);
         end
      end
   endtask

   task automatic test_basic_sweep();
      logic [31:0] inst; logic [1:0] err; int lat; bit held; logic prv, prr;
      for (int w = 0; w < 4; w++) begin
         run_fetch(1, 32'(w * 4), 0, inst, err, lat, held, prv, prr);
         tests_run++;
         if (inst !== model_mem[w] || err !== 2'b00 || lat !== 2 || prv !== 1'b0 || prr !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_fetch[%0d]: got inst=%h err=%b lat=%0d post rv=%b rr=%b, want inst=%h err=00 lat=2 rv=0 rr=1",
                     w, inst, err, lat, prv, prr, model_mem[w]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] inst; logic [1:0] err; int lat; bit held; logic prv, prr;
      run_fetch(1, 32'h4, 5, inst, err, lat, held, prv, prr);
      tests_run++;
      if (inst !== model_mem[1] || held !== 1'b1 || prv !== 1'b0 || prr !== 1'b1) begin
         tests_failed++;
         $display("FAIL backpressure: got inst=%h held=%b post rv=%b rr=%b, want inst=%h held=1 rv=0 rr=1",
                  inst, held, prv, prr, model_mem[1]);
      end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [3] = '{32'h6, 32'h400, 32'h402};
      logic [1:0]  errs  [3] = '{2'b01, 2'b10, 2'b11};
      logic [31:0] inst; logic [1:0] err; int lat; bit held; logic prv, prr;
      for (int i = 0; i < 3; i++) begin
         run_fetch(1, addrs[i], 0, inst, err, lat, held, prv, prr);
         tests_run++;
         if (inst !== NOP || err !== errs[i] || prv !== 1'b0 || prr !== 1'b1) begin
            tests_failed++;
            $display("FAIL error_fetch[%h]: got inst=%h err=%b, want inst=%h err=%b",
                     addrs[i], inst, err, NOP, errs[i]);
         end
      end
   endtask

   task automatic test_latency();
      logic [31:0] inst; logic [1:0] err; int lat; bit held; logic prv, prr;
      for (int s = 0; s < 3; s += 2) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
         run_fetch(s, a, 0, inst, err, lat, held, prv, prr);
         tests_run++;
         if (lat !== 1 + wait_of[s] || inst !== exp_inst(a) || err !== 2'b00) begin
            tests_failed++;
            $display("FAIL latency[w=%0d]: got lat=%0d inst=%h, want lat=%0d inst=%h",
                     wait_of[s], lat, inst, 1 + wait_of[s], exp_inst(a));
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      logic [31:0] inst; logic [1:0] err; int lat; bit held; logic prv, prr;
      sel = 1; req_addr = 32'h4; resp_ready = 1'b1; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      tests_run++;
      if (cur_rr !== 1'b1 || cur_rv !== 1'b0 || cur_ri !== 32'h0 || cur_re !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_mid_state: got rr=%b rv=%b inst=%h err=%b, want rr=1 rv=0 inst=0 err=00",
                  cur_rr, cur_rv, cur_ri, cur_re);
      end
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (cur_rv !== 1'b0) seen = 1'b1;
      end
      resp_ready = 1'b0;
      tests_run++;
      if (seen !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_dropped: got a response for the dropped request, want none");
      end
      run_fetch(1, 32'h0, 0, inst, err, lat, held, prv, prr);
      tests_run++;
      if (inst !== 32'h0050_0093 || err !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_mid_mem: got inst=%h err=%b, want inst=00500093 err=00", inst, err);
      end
   endtask

   task automatic test_collision();
      logic [31:0] inst; logic [1:0] err; int lat; bit held; logic prv, prr;
      logic [31:0] old_word;
      old_word = model_mem[2];
      sel = 1; req_addr = 32'h8; resp_ready = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      ld_en = 1'b1; ld_addr = 8'd2; ld_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      ld_en = 1'b0;
      model_mem[2] = 32'hDEAD_BEEF;
      tests_run++;
      if (cur_rv !== 1'b1 || cur_ri !== old_word) begin
         tests_failed++;
         $display("FAIL collision_old: got rv=%b inst=%h, want rv=1 inst=%h", cur_rv, cur_ri, old_word);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      run_fetch(1, 32'h8, 0, inst, err, lat, held, prv, prr);
      tests_run++;
      if (inst !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL collision_new: got inst=%h, want inst=deadbeef", inst);
      end
   endtask

   task automatic test_write_in_wait();
      logic [31:0] nw;
      int lat;
      nw = $urandom;
      sel = 2; req_addr = 32'h14; resp_ready = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      ld_en = 1'b1; ld_addr = 8'd5; ld_data = nw;
      @(posedge clk); #1;
      ld_en = 1'b0;
      model_mem[5] = nw;
      lat = 2;
      while (cur_rv !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      tests_run++;
      if (cur_ri !== nw || lat !== 4) begin
         tests_failed++;
         $display("FAIL write_in_wait: got inst=%h lat=%0d, want inst=%h lat=4", cur_ri, lat, nw);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] inst; logic [1:0] err; int lat; bit held; logic prv, prr;
      for (int n = 0; n < 40; n++) begin
         int s, mode;
         logic [31:0] a;
         s = $urandom_range(0, 2);
         mode = $urandom_range(0, 3);
         case (mode)
            0: a = $urandom;
            1: a = 32'($urandom_range(32'h3F0, 32'h40F));
            2: a = 32'($urandom_range(0, 4 * DEPTH - 1));
            default: a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
         endcase
         if ($urandom_range(0, 2) == 0) load_word($urandom_range(4, DEPTH - 1), $urandom);
         run_fetch(s, a, $urandom_range(0, 3), inst, err, lat, held, prv, prr);
         tests_run++;
         if (inst !== exp_inst(a) || err !== exp_err(a) || lat !== 1 + wait_of[s] ||
             held !== 1'b1 || prv !== 1'b0 || prr !== 1'b1) begin
            tests_failed++;
            $display("FAIL random[%0d] w=%0d addr=%h: got inst=%h err=%b lat=%0d held=%b, want inst=%h err=%b lat=%0d held=1",
                     n, wait_of[s], a, inst, err, lat, held, exp_inst(a), exp_err(a), 1 + wait_of[s]);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      tests_failed++;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_addr = 32'h0;
      ld_en = 1'b0; ld_addr = 8'h0; ld_data = 32'h0; sel = 1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      for (int i = 4; i < DEPTH; i++) load_word(i, $urandom);
      load_word(0, 32'h0050_0093);
      load_word(1, 32'h00A0_0113);
      load_word(2, 32'h0020_81B3);
      load_word(3, 32'h0000_0063);
      test_basic_sweep();
      test_backpressure();
      test_errors();
      test_latency();
      test_reset_mid();
      test_collision();
      test_write_in_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
